// File: rtl/result_arbiter_pkg.sv
// Shared definitions for the result arbiter: FSM encoding, defaults, count width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package result_arbiter_pkg;

  // Flush sequencing states.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_WAIT = 2'd1,
    DONE       = 2'd2
  } arbState_t;

  // Idle cycles required before a flush is declared complete.
  localparam int DEFAULT_QUIET_CYCLES = 64;

  // Width of the accepted-results counter.
  localparam int COUNT_WIDTH = 32;

endpackage

// File: rtl/result_arbiter_picker.sv
// Round-robin picker: first valid index at or after ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; a grant is produced whenever any valid is set.
module round_robin_picker #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grantIdx,
  output logic               anyGrant
);

  // Two passes: indices >= ptr get priority, then the wrapped indices below ptr.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!anyGrant && valid[i] && (i >= int'(ptr))) begin
        grant[i] = 1'b1;
        grantIdx = PTR_W'(i);
        anyGrant = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!anyGrant && valid[i] && (i < int'(ptr))) begin
        grant[i] = 1'b1;
        grantIdx = PTR_W'(i);
        anyGrant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// Merges NUM_REQ result streams into one buffer write port; gates issue; flush sequencing.
// Latency: 1 cycle from grant to outValid/outData.
// Backpressure: none downstream; a grant is issued every cycle any reqValid is set.
module result_arbiter
  import result_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 64,
  parameter int QUIET_CYCLES = DEFAULT_QUIET_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       reqValid,
  input  logic [NUM_REQ*WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]       reqReady,
  input  logic                     bufSlow,
  output logic                     issueEnable,
  output logic                     outValid,
  output logic [WIDTH-1:0]         outData,
  input  logic                     flush,
  output logic                     flushDone,
  output logic [COUNT_WIDTH-1:0]   resultCount
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int QC_W  = $clog2(QUIET_CYCLES + 1);
  localparam logic [QC_W-1:0]  QC_MAX   = QC_W'(QUIET_CYCLES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] pickGrant;
  logic [PTR_W-1:0]   pickIdx;
  logic               pickAny;
  logic [WIDTH-1:0]   selData;
  logic [QC_W-1:0]    qc;
  logic [QC_W-1:0]    qcNext;
  logic               activity;
  arbState_t          state;
  arbState_t          nextState;

  round_robin_picker #(.NUM_REQ(NUM_REQ)) picker (
    .valid    (reqValid),
    .ptr      (ptr),
    .grant    (pickGrant),
    .grantIdx (pickIdx),
    .anyGrant (pickAny)
  );

  // Grants are suppressed while in reset so nothing is consumed and then dropped.
  assign reqReady = rst ? '0 : pickGrant;

  // One-hot data mux driven by the picker's grant vector.
  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickGrant[i]) selData = reqData[i*WIDTH +: WIDTH];
    end
  end

  // Pointer advances past the granted index; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (pickAny) ptr <= (pickIdx == LAST_IDX) ? '0 : pickIdx + PTR_W'(1);
  end

  // Registered write port and accepted-result counter; outData holds between grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid    <= 1'b0;
      outData     <= '0;
      resultCount <= '0;
    end else begin
      outValid <= pickAny;
      if (pickAny) begin
        outData     <= selData;
        resultCount <= resultCount + COUNT_WIDTH'(1);
      end
    end
  end

  // An in-flight write counts as activity so the last result lands before quiet counting.
  assign activity = (|reqValid) | outValid;

  // Flush FSM state and quiet counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      qc    <= '0;
    end else begin
      state <= nextState;
      qc    <= qcNext;
    end
  end

  // Next-state and quiet-count logic; the counter saturates at QUIET_CYCLES.
  always_comb begin
    nextState = state;
    qcNext    = qc;
    case (state)
      RUN: begin
        qcNext = '0;
        if (flush) nextState = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (activity)          qcNext = '0;
        else if (qc != QC_MAX) qcNext = qc + QC_W'(1);
        if (qcNext == QC_MAX)  nextState = DONE;
      end
      DONE: begin
        qcNext    = '0;
        nextState = flush ? FLUSH_WAIT : RUN;
      end
      default: begin
        qcNext    = '0;
        nextState = RUN;
      end
    endcase
  end

  assign issueEnable = !rst && (state == RUN) && !bufSlow;
  assign flushDone   = !rst && (state == DONE);

endmodule

// File: tb/tb_result_arbiter.sv
// Self-checking bench for result_arbiter against a behavioural reference model.
// Latency: model expects outputs one cycle after each grant.
// Backpressure: none exercised; the design has no downstream stall.
module tb_result_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int QC = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqValid;
  logic [N*W-1:0] reqData;
  logic [N-1:0]   reqReady;
  logic           bufSlow;
  logic           issueEnable;
  logic           outValid;
  logic [W-1:0]   outData;
  logic           flush;
  logic           flushDone;
  logic [31:0]    resultCount;

  result_arbiter #(.NUM_REQ(N), .WIDTH(W), .QUIET_CYCLES(QC)) dut (
    .clk         (clk),
    .rst         (rst),
    .reqValid    (reqValid),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .bufSlow     (bufSlow),
    .issueEnable (issueEnable),
    .outValid    (outValid),
    .outData     (outData),
    .flush       (flush),
    .flushDone   (flushDone),
    .resultCount (resultCount)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = running, 1 = waiting for quiet, 2 = done pulse.
  int          mPtr;
  logic        mOutValid;
  logic [W-1:0] mOutData;
  logic [31:0] mCount;
  int          mPhase;
  int          mQuiet;

  int nAssert = 0;
  int nFail   = 0;
  int cycNum  = 0;
  int lastOv  = -1;
  int doneAt  = -1;
  int doneSeen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] randData();
    logic [N*W-1:0] d;
    for (int i = 0; i < N*2; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic modelReset();
    mPtr = 0; mOutValid = 1'b0; mOutData = '0; mCount = '0; mPhase = 0; mQuiet = 0;
  endtask

  // One clock: drive at negedge, check shortly after, advance model, wait for posedge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic slow, input logic fl, input logic r);
    int k;
    logic [N-1:0] g;
    logic act;
    @(negedge clk);
    reqValid = v; reqData = d; bufSlow = slow; flush = fl; rst = r;
    #1;
    k = -1;
    if (!r) begin
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (mPtr + off) % N;
        if (k < 0 && v[idx]) k = idx;
      end
    end
    g = '0;
    if (k >= 0) g[k] = 1'b1;
    chk("reqReady",    64'(reqReady),    64'(g));
    chk("issueEnable", 64'(issueEnable), 64'(!r && mPhase == 0 && !slow));
    chk("flushDone",   64'(flushDone),   64'(!r && mPhase == 2));
    chk("outValid",    64'(outValid),    64'(mOutValid));
    chk("outData",     outData,          mOutData);
    chk("resultCount", 64'(resultCount), 64'(mCount));
    if (outValid === 1'b1) lastOv = cycNum;
    if (flushDone === 1'b1) begin doneAt = cycNum; doneSeen++; end
    act = (|v) | mOutValid;
    if (r) begin
      modelReset();
    end else begin
      if (k >= 0) begin
        mPtr = (k + 1) % N;
        mOutValid = 1'b1;
        mOutData = d[k*W +: W];
        mCount = mCount + 32'd1;
      end else begin
        mOutValid = 1'b0;
      end
      case (mPhase)
        0: if (fl) begin mPhase = 1; mQuiet = 0; end
        1: begin
          if (act) mQuiet = 0; else mQuiet++;
          if (mQuiet == QC) mPhase = 2;
        end
        default: if (fl) begin mPhase = 1; mQuiet = 0; end else mPhase = 0;
      endcase
    end
    cycNum++;
    @(posedge clk);
  endtask

  initial begin
    int d0;
    logic rt;
    rst = 1'b1; reqValid = '0; reqData = '0; bufSlow = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();

    // Reset with activity on the inputs: nothing may be granted.
    cycle(4'hF, randData(), 1'b0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);

    // Fairness: all requesters valid for 8 cycles.
    for (int i = 0; i < 8; i++) cycle(4'hF, randData(), 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("fairCount", 64'(resultCount), 64'd8);

    // Sparse wrap: steer ptr to 3, then single and split requests.
    cycle(4'b0100, randData(), 1'b0, 1'b0, 1'b0);
    cycle(4'b0010, randData(), 1'b0, 1'b0, 1'b0);
    cycle(4'b1001, randData(), 1'b0, 1'b0, 1'b0);
    cycle(4'b1001, randData(), 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);

    // Throttle: bufSlow window with grants still flowing.
    for (int i = 0; i < 20; i++)
      cycle(4'($urandom), randData(), (i >= 5 && i < 15), 1'b0, 1'b0);

    // Flush while requester 2 has three results pending.
    d0 = doneSeen;
    cycle(4'b0100, randData(), 1'b0, 1'b1, 1'b0);
    cycle(4'b0100, randData(), 1'b0, 1'b0, 1'b0);
    cycle(4'b0100, randData(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle('0, '0, 1'b0, 1'b0, 1'b0);
    chk("flushPulses", 64'(doneSeen - d0), 64'd1);
    chk("flushGap", 64'(doneAt - lastOv), 64'(QC + 1));

    // Re-trigger: ignored in FLUSH_WAIT, restarts from DONE.
    d0 = doneSeen;
    rt = 1'b0;
    cycle('0, '0, 1'b0, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic f;
      f = (mPhase == 2) && !rt;
      if (f) rt = 1'b1;
      cycle('0, '0, 1'b0, f, 1'b0);
    end
    chk("retrigPulses", 64'(doneSeen - d0), 64'd2);

    // Reset in FLUSH_WAIT: back to RUN, no done pulse.
    d0 = doneSeen;
    cycle(4'b0001, randData(), 1'b0, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);
    cycle(4'hF, randData(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle('0, '0, 1'b0, 1'b0, 1'b0);
    chk("rstNoDone", 64'(doneSeen - d0), 64'd0);

    // Randomized traffic with occasional flush, throttle and reset.
    for (int i = 0; i < 400; i++)
      cycle(4'($urandom), randData(), ($urandom_range(3) == 0),
            ($urandom_range(15) == 0), ($urandom_range(63) == 0));

    // Counter wrap: preload all-ones then grant once more.
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    force dut.resultCount = 32'hFFFF_FFFF;
    #1;
    release dut.resultCount;
    mCount = 32'hFFFF_FFFF;
    cycle(4'b0001, randData(), 1'b0, 1'b0, 1'b0);
    cycle('0, '0, 1'b0, 1'b0, 1'b0);
    chk("countWrap", 64'(resultCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no completion, expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
